// File: rtl/telemetry_pkg.sv
// Shared constants and state/error encodings for the telemetry receiver.
package telemetry_pkg;

  localparam logic [7:0] SYNC0 = 8'hAA;
  localparam logic [7:0] SYNC1 = 8'h55;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'b00,
    ERR_FRAME = 2'b01,
    ERR_FMT   = 2'b10,
    ERR_TMO   = 2'b11
  } err_code_e;

  typedef enum logic [2:0] {
    PS_HUNT_AA,
    PS_HUNT_55,
    PS_B0,
    PS_B1,
    PS_B2,
    PS_B3,
    PS_B4,
    PS_B5
  } pkt_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_RECOV
  } rx_state_e;

endpackage

// File: rtl/telemetry_rx_uart_rx.sv
// 8N1 UART byte receiver: RX synchroniser, mid-bit sampling baud counter and byte FSM.
module uart_rx
  import telemetry_pkg::*;
#(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  output logic [7:0] rx_data,
  output logic       rx_rdy,
  output logic       frm_err
);

  localparam logic [15:0] FULL_M1 = 16'(BAUD_DIV - 1);
  localparam logic [15:0] HALF_M1 = 16'(BAUD_DIV / 2 - 1);

  rx_state_e   state_q, state_d;
  logic        sync1_q, sync1_d;
  logic        sync2_q, sync2_d;
  logic        prev_q, prev_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        rdy_q, rdy_d;
  logic        frm_q, frm_d;
  logic        expired;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      rdy_q   <= 1'b0;
      frm_q   <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      rdy_q   <= rdy_d;
      frm_q   <= frm_d;
    end
  end

  always_comb begin
    sync1_d = RX;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    state_d = state_q;
    cnt_d   = (cnt_q != 16'd0) ? cnt_q - 16'd1 : cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    rdy_d   = 1'b0;
    frm_d   = 1'b0;
    expired = (cnt_q == 16'd0);

    case (state_q)
      RX_IDLE: begin
        if (prev_q && !sync2_q) begin
          state_d = RX_START;
          cnt_d   = HALF_M1;
        end
      end
      RX_START: begin
        if (expired) begin
          if (!sync2_q) begin
            state_d = RX_DATA;
            cnt_d   = FULL_M1;
            bit_d   = 3'd0;
          end else begin
            state_d = RX_IDLE;
          end
        end
      end
      RX_DATA: begin
        if (expired) begin
          shift_d = {sync2_q, shift_q[7:1]};
          cnt_d   = FULL_M1;
          if (bit_q == 3'd7) begin
            state_d = RX_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      RX_STOP: begin
        if (expired) begin
          if (sync2_q) begin
            rdy_d   = 1'b1;
            state_d = RX_IDLE;
          end else begin
            frm_d   = 1'b1;
            state_d = RX_RECOV;
            cnt_d   = FULL_M1;
          end
        end
      end
      RX_RECOV: begin
        // Line must stay high for a whole bit before hunting for a new start.
        if (!sync2_q) begin
          cnt_d = FULL_M1;
        end else if (expired) begin
          state_d = RX_IDLE;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign rx_data = shift_q;
  assign rx_rdy  = rdy_q;
  assign frm_err = frm_q;

endmodule

// File: rtl/telemetry_rx.sv
// Telemetry packet receiver: frames AA 55 + six field bytes from the UART and reports errors.
module telemetry_rx
  import telemetry_pkg::*;
#(
  parameter int BAUD_DIV = 2604,
  parameter int TIMEOUT  = 65536
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  output logic [11:0] batt,
  output logic [11:0] curr,
  output logic [11:0] torque,
  output logic        pkt_rdy,
  output logic [15:0] pkt_cnt,
  output logic        err,
  output logic [1:0]  err_code
);

  localparam int            GW      = $clog2(TIMEOUT + 1);
  localparam logic [GW-1:0] GAP_MAX = GW'(TIMEOUT);

  logic [7:0] rx_data;
  logic       rx_rdy;
  logic       frm_err;

  uart_rx #(.BAUD_DIV(BAUD_DIV)) u_uart_rx (
    .clk     (clk),
    .rst     (rst),
    .RX      (RX),
    .rx_data (rx_data),
    .rx_rdy  (rx_rdy),
    .frm_err (frm_err)
  );

  pkt_state_e    state_q, state_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [3:0]    hi_q, hi_d;
  logic [11:0]   sh_batt_q, sh_batt_d;
  logic [11:0]   sh_curr_q, sh_curr_d;
  logic [11:0]   batt_q, batt_d;
  logic [11:0]   curr_q, curr_d;
  logic [11:0]   torque_q, torque_d;
  logic          pkt_rdy_q, pkt_rdy_d;
  logic [15:0]   pkt_cnt_q, pkt_cnt_d;
  logic          err_q, err_d;
  err_code_e     err_code_q, err_code_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= PS_HUNT_AA;
      gap_q      <= '0;
      hi_q       <= '0;
      sh_batt_q  <= '0;
      sh_curr_q  <= '0;
      batt_q     <= '0;
      curr_q     <= '0;
      torque_q   <= '0;
      pkt_rdy_q  <= 1'b0;
      pkt_cnt_q  <= '0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      hi_q       <= hi_d;
      sh_batt_q  <= sh_batt_d;
      sh_curr_q  <= sh_curr_d;
      batt_q     <= batt_d;
      curr_q     <= curr_d;
      torque_q   <= torque_d;
      pkt_rdy_q  <= pkt_rdy_d;
      pkt_cnt_q  <= pkt_cnt_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    gap_d      = (state_q == PS_HUNT_AA || rx_rdy) ? '0 : gap_q + GW'(1);
    hi_d       = hi_q;
    sh_batt_d  = sh_batt_q;
    sh_curr_d  = sh_curr_q;
    batt_d     = batt_q;
    curr_d     = curr_q;
    torque_d   = torque_q;
    pkt_rdy_d  = 1'b0;
    pkt_cnt_d  = pkt_cnt_q;
    err_d      = 1'b0;
    err_code_d = ERR_NONE;

    if (frm_err) begin
      err_d      = 1'b1;
      err_code_d = ERR_FRAME;
      state_d    = PS_HUNT_AA;
      gap_d      = '0;
    end else if (rx_rdy) begin
      case (state_q)
        PS_HUNT_AA: if (rx_data == SYNC0) state_d = PS_HUNT_55;
        PS_HUNT_55: begin
          if (rx_data == SYNC1)      state_d = PS_B0;
          else if (rx_data != SYNC0) state_d = PS_HUNT_AA;
        end
        PS_B0, PS_B2, PS_B4: begin
          if (rx_data[7:4] != 4'h0) begin
            err_d      = 1'b1;
            err_code_d = ERR_FMT;
            state_d    = PS_HUNT_AA;
          end else begin
            hi_d    = rx_data[3:0];
            state_d = (state_q == PS_B0) ? PS_B1 :
                      (state_q == PS_B2) ? PS_B3 : PS_B5;
          end
        end
        PS_B1: begin
          sh_batt_d = {hi_q, rx_data};
          state_d   = PS_B2;
        end
        PS_B3: begin
          sh_curr_d = {hi_q, rx_data};
          state_d   = PS_B4;
        end
        PS_B5: begin
          // All three fields commit together so observers never see a mixed packet.
          batt_d    = sh_batt_q;
          curr_d    = sh_curr_q;
          torque_d  = {hi_q, rx_data};
          pkt_rdy_d = 1'b1;
          pkt_cnt_d = (pkt_cnt_q == 16'hFFFF) ? pkt_cnt_q : pkt_cnt_q + 16'd1;
          state_d   = PS_HUNT_AA;
        end
        default: state_d = PS_HUNT_AA;
      endcase
    end else if (state_q != PS_HUNT_AA && gap_q == GAP_MAX) begin
      err_d      = 1'b1;
      err_code_d = ERR_TMO;
      state_d    = PS_HUNT_AA;
      gap_d      = '0;
    end
  end

  assign batt     = batt_q;
  assign curr     = curr_q;
  assign torque   = torque_q;
  assign pkt_rdy  = pkt_rdy_q;
  assign pkt_cnt  = pkt_cnt_q;
  assign err      = err_q;
  assign err_code = err_code_q;

endmodule

// File: tb/tb_telemetry_rx.sv
// Self-checking bench: byte-level packet model feeds an expected-event queue checked every cycle.
module tb_telemetry_rx;

  localparam int BAUD = 16;
  localparam int TMO  = 1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        RX  = 1'b1;
  logic [11:0] batt, curr, torque;
  logic        pkt_rdy, err;
  logic [15:0] pkt_cnt;
  logic [1:0]  err_code;

  always #5 clk = ~clk;

  telemetry_rx #(.BAUD_DIV(BAUD), .TIMEOUT(TMO)) dut (
    .clk      (clk),
    .rst      (rst),
    .RX       (RX),
    .batt     (batt),
    .curr     (curr),
    .torque   (torque),
    .pkt_rdy  (pkt_rdy),
    .pkt_cnt  (pkt_cnt),
    .err      (err),
    .err_code (err_code)
  );

  typedef struct {
    bit          is_pkt;
    logic [1:0]  code;
    logic [11:0] b, c, t;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] seq[$];
  int         n_checks = 0;
  int         n_pass   = 0;

  // Packet model: 0 = hunting AA, 1 = hunting 55, 2..7 = body byte index + 2.
  int         st = 0;
  logic [7:0] body [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic push_err(input logic [1:0] code);
    ev_t e;
    e.is_pkt = 1'b0; e.code = code; e.b = '0; e.c = '0; e.t = '0;
    exp_q.push_back(e);
  endtask

  task automatic model_byte(input logic [7:0] b);
    ev_t e;
    int  k;
    if (st == 0) begin
      if (b == 8'hAA) st = 1;
    end else if (st == 1) begin
      if (b == 8'h55) st = 2;
      else if (b != 8'hAA) st = 0;
    end else begin
      k = st - 2;
      if ((k % 2 == 0) && (b[7:4] != 4'h0)) begin
        push_err(2'b10);
        st = 0;
      end else begin
        body[k] = b;
        if (k == 5) begin
          e.is_pkt = 1'b1; e.code = 2'b00;
          e.b = {body[0][3:0], body[1]};
          e.c = {body[2][3:0], body[3]};
          e.t = {body[4][3:0], body[5]};
          exp_q.push_back(e);
          st = 0;
        end else begin
          st++;
        end
      end
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    RX = 1'b0;
    wait_cyc(BAUD);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      wait_cyc(BAUD);
    end
    if (stop_ok) model_byte(b);
    else begin
      push_err(2'b01);
      st = 0;
    end
    RX = stop_ok;
    wait_cyc(BAUD);
    if (!stop_ok) begin
      RX = 1'b1;
      wait_cyc(2 * BAUD);
    end
  endtask

  task automatic idle(input int n);
    if (n >= TMO && st != 0) begin
      push_err(2'b11);
      st = 0;
    end
    RX = 1'b1;
    if (n > 0) wait_cyc(n);
    if (n >= 4) check("events_drained", exp_q.size(), 0);
  endtask

  task automatic send_seq(input int gap);
    while (seq.size() > 0) begin
      send_byte(seq.pop_front(), 1'b1);
      idle(gap);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    RX  = 1'b1;
    wait_cyc(1);
    rst = 1'b0;
    st  = 0;
    check("rst_batt", batt, 0);
    check("rst_curr", curr, 0);
    check("rst_torque", torque, 0);
    check("rst_cnt", pkt_cnt, 0);
    check("rst_flags", {pkt_rdy, err}, 0);
  endtask

  task automatic check_fields(input string tag, input logic [11:0] b, input logic [11:0] c,
                              input logic [11:0] t, input logic [15:0] n);
    check({tag, "_batt"}, batt, b);
    check({tag, "_curr"}, curr, c);
    check({tag, "_torque"}, torque, t);
    check({tag, "_cnt"}, pkt_cnt, n);
  endtask

  // Compare process: every DUT event must match the next expected one; fields hold between packets.
  logic [11:0] lb = '0, lc = '0, lt = '0;
  logic [15:0] lcnt = '0;
  always @(negedge clk) begin
    ev_t e;
    if (rst) begin
      exp_q.delete();
      lb = '0; lc = '0; lt = '0; lcnt = '0;
    end else begin
      if (pkt_rdy || err) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event", {pkt_rdy, err, err_code}, 0);
        end else begin
          e = exp_q.pop_front();
          check("event", {pkt_rdy, err, err_code}, e.is_pkt ? 4'b1000 : {2'b01, e.code});
          if (e.is_pkt) begin
            lb = e.b; lc = e.c; lt = e.t;
            if (lcnt != 16'hFFFF) lcnt = lcnt + 16'd1;
            $display("pkt  t=%0t batt=%03h curr=%03h torque=%03h cnt=%0d", $time, batt, curr, torque, pkt_cnt);
          end else begin
            $display("err  t=%0t code=%0d", $time, err_code);
          end
        end
      end
      check("batt", batt, lb);
      check("curr", curr, lc);
      check("torque", torque, lt);
      check("pkt_cnt", pkt_cnt, lcnt);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    wait_cyc(3);
    do_reset();
    idle(40);

    // Nominal packet
    seq = '{8'hAA, 8'h55, 8'h0B, 8'h11, 8'h00, 8'h3C, 8'h0F, 8'hFF};
    send_seq(0);
    idle(20);
    check_fields("nominal", 12'hB11, 12'h03C, 12'hFFF, 16'd1);
    check("nominal_err", err, 0);

    // Noise and resync on repeated AA
    seq = '{8'h12, 8'hAA, 8'hAA, 8'h55, 8'h01, 8'h23, 8'h04, 8'h56, 8'h07, 8'h89};
    send_seq(3);
    idle(20);
    check_fields("resync", 12'h123, 12'h456, 12'h789, 16'd2);

    // Framing error on B3 leaves fields untouched
    seq = '{8'hAA, 8'h55, 8'h0A, 8'hBC, 8'h0D};
    send_seq(5);
    send_byte(8'hEF, 1'b0);
    idle(20);
    check_fields("frame", 12'h123, 12'h456, 12'h789, 16'd2);
    seq = '{8'hAA, 8'h55, 8'h0F, 8'h00, 8'h0E, 8'h11, 8'h0D, 8'h22};
    send_seq(2);
    idle(20);
    check_fields("after_frame", 12'hF00, 12'hE11, 12'hD22, 16'd3);

    // Format error on B2, remaining bytes are hunt noise
    seq = '{8'hAA, 8'h55, 8'h01, 8'h02, 8'h1C, 8'h03, 8'h04, 8'h05,
            8'hAA, 8'h55, 8'h0A, 8'hBC, 8'h0D, 8'hEF, 8'h01, 8'h23};
    send_seq(4);
    idle(20);
    check_fields("after_fmt", 12'hABC, 12'hDEF, 12'h123, 16'd4);

    // Timeout after B0
    seq = '{8'hAA, 8'h55, 8'h0B};
    send_seq(0);
    idle(TMO + 500);
    seq = '{8'h11, 8'h00, 8'h3C, 8'h0F, 8'hFF};
    send_seq(0);
    idle(20);
    check_fields("after_tmo", 12'hABC, 12'hDEF, 12'h123, 16'd4);

    // Short low glitch on idle line
    RX = 1'b0;
    wait_cyc(4);
    idle(100);

    // Reset in the middle of B1's data bits
    seq = '{8'hAA, 8'h55, 8'h0B};
    send_seq(0);
    RX = 1'b0; wait_cyc(BAUD);
    RX = 1'b1; wait_cyc(BAUD);
    RX = 1'b0; wait_cyc(BAUD);
    do_reset();
    idle(3 * BAUD);
    seq = '{8'hAA, 8'h55, 8'h0B, 8'h11, 8'h00, 8'h3C, 8'h0F, 8'hFF};
    send_seq(1);
    idle(20);
    check_fields("after_rst", 12'hB11, 12'h03C, 12'hFFF, 16'd1);

    // Randomized packets with noise, bad stops, format errors and timeouts
    for (int p = 0; p < 18; p++) begin
      logic [7:0] pk[8];
      int nn;
      nn = $urandom_range(0, 2);
      for (int i = 0; i < nn; i++) begin
        send_byte(8'($urandom_range(0, 255)), 1'b1);
        idle($urandom_range(0, 40));
      end
      pk[0] = 8'hAA;
      pk[1] = 8'h55;
      for (int i = 0; i < 6; i++) begin
        if (i % 2 == 0 && $urandom_range(0, 9) != 0) pk[i+2] = {4'h0, 4'($urandom_range(0, 15))};
        else pk[i+2] = 8'($urandom_range(0, 255));
      end
      for (int i = 0; i < 8; i++) begin
        send_byte(pk[i], $urandom_range(0, 29) != 0);
        idle(($urandom_range(0, 29) == 0) ? TMO + 300 : $urandom_range(0, 40));
      end
    end

    idle(4 * BAUD);
    check("final_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/telemetry_rx.md
Name: telemetry_rx

Overview:
Receive-side counterpart of the eBike TX telemetry output, used in benches and on a host-side monitor FPGA.
- Deserialises the 8N1 UART stream from TX.
- Frames the fixed 8-byte telemetry packet: 0xAA, 0x55, batt hi/lo, avg_curr hi/lo, avg_torque hi/lo.
- Presents the three 12-bit fields with a one-cycle valid pulse.
- Flags framing, format and timeout errors.

Parameters:
- BAUD_DIV, 2604: clocks per UART bit (50 MHz / 19200 baud); legal range 16..65535.
- TIMEOUT, 65536: max clocks allowed between consecutive byte completions inside a packet.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset; one clock.
- RX  in  1  serial input from eBike TX; asynchronous; idles high.
- batt  out  12  battery field of the last good packet.
- curr  out  12  avg_curr field of the last good packet.
- torque  out  12  avg_torque field of the last good packet.
- pkt_rdy  out  1  one-cycle pulse; the outputs above were updated this cycle.
- pkt_cnt  out  16  count of good packets; saturates at 0xFFFF.
- err  out  1  one-cycle pulse on any error.
- err_code  out  2  valid when err=1: 01 framing, 10 format, 11 timeout.

Behaviour:
- Reset values:
  - All outputs 0; the RX synchroniser flops reset to 1.
  - Both FSMs go to idle/hunt.
  - rst asserted mid-byte or mid-packet discards all partial data.
- RX passes through a 2-flop synchroniser. Edge detection is on the synchronised value only.
- Byte receiver FSM, states IDLE, START, DATA, STOP:
  - IDLE: falling edge (1 then 0) -> START. Load the baud counter with BAUD_DIV/2.
  - START: at counter expiry, if RX=0 -> DATA. If RX=1, the start was a glitch -> IDLE with no error.
  - DATA: sample every BAUD_DIV clocks. LSB first. After 8 samples -> STOP.
  - STOP: sample once at mid-bit. RX=1 gives byte_vld for one cycle with the byte. RX=0 gives a framing error.
  - On a framing error, stay out of IDLE until RX has been 1 for one full bit time.
  - Next start detection is enabled immediately after the stop sample, so back-to-back bytes are supported.
- Packet FSM, states HUNT_AA, HUNT_55, B0..B5:
  - HUNT_AA: byte 0xAA -> HUNT_55. Other bytes are ignored silently.
  - HUNT_55: 0x55 -> B0. 0xAA stays in HUNT_55 (resync). Any other byte -> HUNT_AA, no error.
  - B0/B2/B4 (high bytes): bits[7:4] must be 0. Otherwise err, code 10, -> HUNT_AA.
  - B5 done: batt/curr/torque are written together in the same cycle. pkt_rdy=1 that cycle. pkt_cnt increments unless already 0xFFFF. -> HUNT_AA.
- Field outputs hold their values until the next good packet; they never show partial updates.
- Framing error in any packet state -> HUNT_AA with err, code 01.
- Framing error while in HUNT_AA -> err, code 01 only.
- Timeout:
  - A gap counter runs in HUNT_55 and B0..B5. It clears on each byte_vld.
  - When it reaches TIMEOUT: err, code 11, -> HUNT_AA.
  - The counter is idle in HUNT_AA.
- Simultaneous events:
  - byte_vld and timeout expiry in the same cycle: the byte wins and the counter clears.
  - Only one err pulse per cycle; framing takes priority over format.
- Latency: pkt_rdy asserts 2 clocks after the stop-bit sample of byte B5 (1 for byte_vld, 1 for register update).

Decomposition:
- Package telemetry_pkg holds:
  - SYNC0 = 8'hAA and SYNC1 = 8'h55.
  - err_code enum: ERR_NONE, ERR_FRAME, ERR_FMT, ERR_TMO.
  - Packet-state enum.
- One sub-module, uart_rx: synchroniser, byte FSM and baud counter. Ports clk, rst, RX, rx_data[7:0], rx_rdy, frm_err.
- telemetry_rx contains the packet FSM, field registers, timeout counter and pkt_cnt.

Test Plan:
- Nominal packet: send AA 55 0B 11 00 3C 0F FF at BAUD_DIV=2604 -> one pkt_rdy; batt=0xB11, curr=0x03C, torque=0xFFF; pkt_cnt=1; no err.
- Resync/noise: send 12 AA AA 55 followed by a valid 6-byte body -> exactly one pkt_rdy with correct fields; no err.
- Framing error: hold the stop bit low on byte B3 -> err, code 01. Fields are unchanged from the previous packet. The next clean packet is accepted.
- Format error: B2 = 0x1C -> err, code 10; no pkt_rdy. Following AA 55 … is decoded correctly.
- Timeout: TIMEOUT=5000. Send AA 55 0B, then idle 6000 clocks -> err, code 11 once. Remaining bytes are treated as hunt noise.
- Reset mid-byte, plus a start glitch: assert rst during the DATA bits of B1 -> all outputs 0 next cycle, and a following full packet decodes. A 100-clock low pulse on idle RX produces no byte and no err.
